// File: rtl/mips_boot_loader.sv
// Byte-stream boot loader: packs a length-prefixed big-endian image into instruction memory.
// Optional trailing XOR checksum byte is enabled with `define BOOT_CHECKSUM_EN.
module mips_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        loaded,
    output logic        error
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef BOOT_CHECKSUM_EN
        CSUM,
`endif
        RUN,
        ERR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state, state_next;
    logic [15:0] count;
    logic [15:0] idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_reg;
    logic        accept;
    logic        do_restart;
    logic        run_set;
    logic [15:0] len_full;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  xsum;
`endif

    assign in_ready   = (state != RUN) && (state != ERR);
    assign accept     = in_valid && in_ready;
    assign do_restart = restart && ((state == RUN) || (state == ERR));
    assign len_full   = {count[15:8], in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LEN_HI;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LEN_HI: if (accept) state_next = LEN_LO;
            LEN_LO: if (accept) begin
                if ({1'b0, len_full} > MAX_W) state_next = ERR;
`ifdef BOOT_CHECKSUM_EN
                else if (len_full == 16'd0)   state_next = CSUM;
`else
                else if (len_full == 16'd0)   state_next = RUN;
`endif
                else                          state_next = DATA;
            end
            DATA: if (accept && byte_cnt == 2'd3 && (idx + 16'd1) == count) begin
`ifdef BOOT_CHECKSUM_EN
                state_next = CSUM;
`else
                state_next = RUN;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: if (accept) state_next = (in_data == xsum) ? RUN : ERR;
`endif
            RUN, ERR: if (restart) state_next = LEN_HI;
            default:  state_next = LEN_HI;
        endcase
    end

    // Leaving DATA for RUN holds the release back one cycle so it follows the final write pulse.
    assign run_set = (state_next == RUN) && (state != DATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            word_reg   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            loaded     <= 1'b0;
            error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            xsum       <= '0;
`endif
        end else begin
            imem_we  <= 1'b0;
            loaded   <= run_set;
            cpu_hold <= !run_set;
            error    <= (state_next == ERR);
            if (do_restart) begin
                count    <= '0;
                idx      <= '0;
                byte_cnt <= '0;
                word_reg <= '0;
`ifdef BOOT_CHECKSUM_EN
                xsum     <= '0;
`endif
            end else if (accept) begin
`ifdef BOOT_CHECKSUM_EN
                xsum <= xsum ^ in_data;
`endif
                case (state)
                    LEN_HI: count[15:8] <= in_data;
                    LEN_LO: count[7:0]  <= in_data;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE_ADDR + {14'b0, idx, 2'b00};
                            imem_wdata <= {word_reg, in_data};
                            idx        <= idx + 16'd1;
                        end else begin
                            word_reg <= {word_reg[15:0], in_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: framing, stalls, length error, restart and mid-load reset.
module tb_mips_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        loaded;
    logic        error;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  img [0:9];

    always #5 clk = ~clk;

    mips_boot_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .loaded(loaded), .error(error)
    );

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic check_image(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() >= 2) begin
            chk({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
            chk({tag, "_d0"}, wr_data[0], 32'h2008_0005);
            chk({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
            chk({tag, "_d1"}, wr_data[1], 32'hAC08_0000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] xs;
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        xs = 8'h00;
        for (int i = 0; i < 10; i++) xs = xs ^ img[i];
        reset = 1'b0; in_valid = 1'b0; in_data = 8'hFF; restart = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_load",  32'(loaded),   32'd0);
        chk("rst_err",   32'(error),    32'd0);
        chk("rst_we",    32'(imem_we),  32'd0);
        chk("rst_addr",  imem_addr,     32'h0);
        chk("rst_wdata", imem_wdata,    32'h0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        // Back-to-back stream
        for (int i = 0; i < 10; i++) send_byte(img[i], 0);
        @(negedge clk);
        chk("t1_we_last", 32'(imem_we),    32'd1);
        chk("t1_addr",    imem_addr,       32'h4);
        chk("t1_wdata",   imem_wdata,      32'hAC08_0000);
        chk("t1_hold_p",  32'(cpu_hold),   32'd1);
        chk("t1_load_p",  32'(loaded),     32'd0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(xs, 0);
`endif
        @(negedge clk);
        chk("t1_hold",  32'(cpu_hold), 32'd0);
        chk("t1_load",  32'(loaded),   32'd1);
        chk("t1_ready", 32'(in_ready), 32'd0);
        chk("t1_we_off", 32'(imem_we), 32'd0);
        check_image("t1");

        // Alternate-cycle stalls, with an ignored restart mid-load
        pulse_restart();
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 10; i++) begin
            if (i == 6) restart = 1'b1;
            send_byte(img[i], 1);
            restart = 1'b0;
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(xs, 1);
`endif
        @(negedge clk);
        chk("t2_load", 32'(loaded), 32'd1);
        check_image("t2");

        // Over-length image
        pulse_restart();
        wr_addr.delete(); wr_data.delete();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        chk("t3_err",   32'(error),    32'd1);
        chk("t3_hold",  32'(cpu_hold), 32'd1);
        chk("t3_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_err_stay", 32'(error), 32'd1);
        chk("t3_nwr", 32'(wr_addr.size()), 32'd0);
        @(posedge clk); #1;
        pulse_restart();
        @(negedge clk);
        chk("t3_err_clr", 32'(error),    32'd0);
        chk("t3_hold2",   32'(cpu_hold), 32'd1);
        chk("t3_ready2",  32'(in_ready), 32'd1);

        // Empty image
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
        @(negedge clk);
        chk("t4_ready_cs", 32'(in_ready), 32'd1);
        send_byte(8'h00, 0);
`endif
        @(negedge clk);
        chk("t4_ready", 32'(in_ready), 32'd0);
        chk("t4_load",  32'(loaded),   32'd1);
        chk("t4_hold",  32'(cpu_hold), 32'd0);
        chk("t4_nwr",   32'(wr_addr.size()), 32'd0);

        // Reset in the middle of a load, then a full retransmit
        @(posedge clk); #1;
        pulse_restart();
        for (int i = 0; i < 5; i++) send_byte(img[i], 0);
        reset = 1'b0;
        #2;
        chk("t5_hold",  32'(cpu_hold), 32'd1);
        chk("t5_ready", 32'(in_ready), 32'd1);
        chk("t5_addr",  imem_addr,     32'h0);
        chk("t5_load",  32'(loaded),   32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 10; i++) send_byte(img[i], 0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(xs, 0);
`endif
        repeat (2) @(negedge clk);
        chk("t5_loaded", 32'(loaded), 32'd1);
        check_image("t5");

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum byte
        pulse_restart();
        for (int i = 0; i < 10; i++) send_byte(img[i], 0);
        send_byte(xs ^ 8'h01, 0);
        @(negedge clk);
        chk("t6_err",  32'(error),    32'd1);
        chk("t6_hold", 32'(cpu_hold), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
